// File: rtl/ultrasonic_echo_meter_if.sv
// Sensor-side bundle for the echo meter.
// The DUT uses the slave view; the driver of pins/consumer uses master.
interface ultrasonic_echo_meter_if;
  logic       start;
  logic       echo;
  logic       trigger;
  logic [7:0] count;
  logic       calculate;
  logic       busy;
  logic       timeout;

  modport master (
    output start,
    output echo,
    input  trigger,
    input  count,
    input  calculate,
    input  busy,
    input  timeout
  );

  modport slave (
    input  start,
    input  echo,
    output trigger,
    output count,
    output calculate,
    output busy,
    output timeout
  );
endinterface

// File: rtl/ultrasonic_echo_meter.sv
// Ultrasonic trigger/echo timer producing a saturating 8-bit width.
// Optional ECHO_GLITCH_FILTER_EN: 3-sample echo debounce.
module ultrasonic_echo_meter #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TICK_DIV       = 1450,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input logic                  clk,
  input logic                  reset,
  ultrasonic_echo_meter_if.slave bus
);

  localparam int TCW = $clog2(TRIG_CYCLES + 1);
  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TCW-1:0] TRIG_LAST = TCW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0]  PSC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TOW-1:0] TO_MAX    = TOW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } state_t;

  state_t         state;
  logic           echo_m;
  logic           echo_s;
  logic           echo_use;
  logic [TCW-1:0] trig_cnt;
  logic [PW-1:0]  psc;
  logic [TOW-1:0] to_cnt;
  logic [TOW-1:0] to_nxt;
  logic           to_hit;
  logic           psc_wrap;

  logic           trigger;
  logic [7:0]     count;
  logic           calculate;
  logic           busy;
  logic           timeout;

  assign to_nxt   = to_cnt + 1'b1;
  assign to_hit   = (to_nxt == TO_MAX);
  assign psc_wrap = (psc == PSC_LAST);

`ifdef ECHO_GLITCH_FILTER_EN
  logic [1:0] echo_h;
  logic       echo_f;

  // Same 3-sample latency on both edges keeps pulse width intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_h <= '0;
      echo_f <= 1'b0;
    end else begin
      echo_h <= {echo_h[0], echo_s};
      if (echo_s == echo_h[0] && echo_s == echo_h[1])
        echo_f <= echo_s;
    end
  end

  assign echo_use = echo_f;
`else
  assign echo_use = echo_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      trig_cnt  <= '0;
      psc       <= '0;
      to_cnt    <= '0;
      trigger   <= 1'b0;
      count     <= '0;
      calculate <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      echo_m    <= bus.echo;
      echo_s    <= echo_m;
      calculate <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= TRIG;
            trigger  <= 1'b1;
            busy     <= 1'b1;
            count    <= '0;
            timeout  <= 1'b0;
            trig_cnt <= '0;
            psc      <= '0;
          end
        end
        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            state   <= WAIT_ECHO;
            trigger <= 1'b0;
            to_cnt  <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        WAIT_ECHO, MEASURE: begin
          to_cnt <= to_nxt;
          // Timeout has priority over an echo edge in the same cycle.
          if (to_hit) begin
            state     <= DONE;
            calculate <= 1'b1;
            count     <= 8'hff;
            timeout   <= 1'b1;
          end else if (state == MEASURE && !echo_use) begin
            state     <= DONE;
            calculate <= 1'b1;
          end else if (echo_use) begin
            state <= MEASURE;
            if (psc_wrap) begin
              psc <= '0;
              if (count != 8'hff)
                count <= count + 8'd1;
            end else begin
              psc <= psc + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trigger   = trigger;
  assign bus.count     = count;
  assign bus.calculate = calculate;
  assign bus.busy      = busy;
  assign bus.timeout   = timeout;

endmodule

// File: tb/tb_ultrasonic_echo_meter.sv
// Directed bench with a {timeout,count} scoreboard per instance.
// Instance a: timeout 100; instance b: timeout 2000.
module tb_ultrasonic_echo_meter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   calc_seen_a = 0;
  int   n;
  int   base;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] ea;
  logic [8:0] eb;
  logic       a_prev = 1'b0;
  logic       b_prev = 1'b0;

  ultrasonic_echo_meter_if ia ();
  ultrasonic_echo_meter_if ib ();

  ultrasonic_echo_meter #(
    .TRIG_CYCLES(4), .TICK_DIV(3), .TIMEOUT_CYCLES(100)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );

  ultrasonic_echo_meter #(
    .TRIG_CYCLES(4), .TICK_DIV(3), .TIMEOUT_CYCLES(2000)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_idle(input bit sel, input int bound);
    int m = 0;
    while (m < bound &&
           (sel ? (qb.size() != 0 || ib.busy === 1'b1)
                : (qa.size() != 0 || ia.busy === 1'b1))) begin
      m++;
      step(1);
    end
    chk(sel ? "b_wait_idle" : "a_wait_idle", 32'(m < bound), 1);
  endtask

  task automatic wait_trig_low(input bit sel, output int cnt);
    cnt = 0;
    while (cnt < 50 && (sel ? ib.trigger : ia.trigger) === 1'b1) begin
      cnt++;
      step(1);
    end
  endtask

  always @(negedge clk) begin
    if (a_prev)
      chk("a_after_calc", {ia.calculate, ia.busy}, 0);
    if (ia.calculate === 1'b1) begin
      calc_seen_a++;
      if (qa.size() == 0) begin
        chk("a_unexpected_calc", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_count", ia.count, ea[7:0]);
        chk("a_timeout", ia.timeout, ea[8]);
        chk("a_busy_in_calc", ia.busy, 1);
      end
    end
    a_prev = ia.calculate;
  end

  always @(negedge clk) begin
    if (b_prev)
      chk("b_after_calc", {ib.calculate, ib.busy}, 0);
    if (ib.calculate === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_calc", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_count", ib.count, eb[7:0]);
        chk("b_timeout", ib.timeout, eb[8]);
      end
    end
    b_prev = ib.calculate;
  end

  initial begin
    reset    = 1'b1;
    ia.start = 1'b1;
    ia.echo  = 1'b1;
    ib.start = 1'b0;
    ib.echo  = 1'b0;
    step(3);
    chk("rst_trigger", ia.trigger, 0);
    chk("rst_count", ia.count, 0);
    chk("rst_calc", ia.calculate, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_timeout", ia.timeout, 0);
    chk("rst_b_busy", ib.busy, 0);

    reset = 1'b0;
    step(1);
    chk("accept_busy", ia.busy, 1);
    chk("accept_trigger", ia.trigger, 1);
    ia.start = 1'b0;
    ia.echo  = 1'b0;
    qa.push_back({1'b1, 8'd255});
    wait_idle(0, 300);

    // 30-cycle echo -> 10 ticks
    qa.push_back({1'b0, 8'd10});
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_trig_low(0, n);
    chk("trig_width", n, 4);
    ia.echo = 1'b1;
    step(30);
    ia.echo = 1'b0;
    wait_idle(0, 300);

    // no echo -> timeout 100 cycles after WAIT_ECHO entry
    qa.push_back({1'b1, 8'd255});
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_trig_low(0, n);
    n = 0;
    while (ia.calculate !== 1'b1 && n < 300) begin
      n++;
      step(1);
    end
    chk("timeout_latency", n, 100);
    wait_idle(0, 300);

    // long echo on instance b saturates without timeout
    qb.push_back({1'b0, 8'd255});
    ib.start = 1'b1;
    step(1);
    ib.start = 1'b0;
    wait_trig_low(1, n);
    ib.echo = 1'b1;
    step(900);
    ib.echo = 1'b0;
    wait_idle(1, 3000);

    // starts while busy are dropped
    qa.push_back({1'b0, 8'd3});
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    step(1);
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_trig_low(0, n);
    ia.echo = 1'b1;
    ia.start = 1'b1;
    step(9);
    ia.echo = 1'b0;
    ia.start = 1'b0;
    wait_idle(0, 300);
    base = calc_seen_a;
    step(150);
    chk("no_queued_start", calc_seen_a - base, 0);
    chk("idle_busy", ia.busy, 0);

    // reset during MEASURE aborts
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_trig_low(0, n);
    ia.echo = 1'b1;
    step(10);
    chk("measure_busy", ia.busy, 1);
    reset = 1'b1;
    step(1);
    chk("abort_busy", ia.busy, 0);
    chk("abort_trigger", ia.trigger, 0);
    chk("abort_count", ia.count, 0);
    reset = 1'b0;
    ia.echo = 1'b0;
    base = calc_seen_a;
    step(150);
    chk("abort_no_calc", calc_seen_a - base, 0);

    // 1-cycle glitch followed by a 30-cycle echo
`ifdef ECHO_GLITCH_FILTER_EN
    qa.push_back({1'b0, 8'd10});
`else
    qa.push_back({1'b0, 8'd0});
`endif
    ia.start = 1'b1;
    step(1);
    ia.start = 1'b0;
    wait_trig_low(0, n);
    ia.echo = 1'b1;
    step(1);
    ia.echo = 1'b0;
    step(5);
    ia.echo = 1'b1;
    step(30);
    ia.echo = 1'b0;
    wait_idle(0, 300);
    step(5);

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
